// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - packs host beats into instruction words and writes them to imem
module imem_prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int BIG_ENDIAN = 0,
  localparam int BEATS     = DATA_WIDTH / IN_WIDTH,
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int CNT_WIDTH = $clog2(MEM_DEPTH) + 1,
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_ready,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  prog_ack,
  output logic                  core_run,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  overflow_err
);

  // FLUSH is the single cycle in which the final word is written before DONE
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERROR} state_t;

  state_t                state;
  logic                  prog_ready_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [CNT_WIDTH-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] pack_nxt;
  logic [BEAT_W-1:0]     slot;
  logic                  xfer;
  logic                  rise;
  logic                  last_slot;
  logic                  mem_full;

  assign in_ready = (state == LOAD);

  // Beat placement, handshake and overflow detection for the current cycle
  always_comb begin
    slot      = (BIG_ENDIAN != 0) ? (BEAT_W'(BEATS - 1) - beat_cnt) : beat_cnt;
    pack_nxt  = pack;
    pack_nxt[slot*IN_WIDTH +: IN_WIDTH] = in_data;
    xfer      = in_valid && in_ready;
    rise      = prog_ready && !prog_ready_q;
    last_slot = (beat_cnt == BEAT_W'(BEATS - 1));
    // wr_idx counts words already handed to memory, so a fresh word beyond capacity is caught here
    mem_full  = (beat_cnt == '0) && (wr_idx == CNT_WIDTH'(MEM_DEPTH));
  end

  // Load FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prog_ready_q <= 1'b0;
      beat_cnt     <= '0;
      wr_idx       <= '0;
      pack         <= '0;
      mem_w_en     <= 1'b0;
      mem_wr_addr  <= '0;
      mem_data     <= '0;
      prog_ack     <= 1'b0;
      core_run     <= 1'b0;
      word_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      prog_ready_q <= prog_ready;
      mem_w_en     <= 1'b0;
      prog_ack     <= 1'b0;
      // word_count trails the write strobe by one cycle
      if (mem_w_en) word_count <= word_count + CNT_WIDTH'(1);
      case (state)
        IDLE, DONE, ERROR: begin
          if (rise) begin
            state        <= LOAD;
            core_run     <= 1'b0;
            word_count   <= '0;
            wr_idx       <= '0;
            beat_cnt     <= '0;
            pack         <= '0;
            overflow_err <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (mem_full) begin
              overflow_err <= 1'b1;
              state        <= ERROR;
            end else if (last_slot || in_last) begin
              mem_w_en    <= 1'b1;
              mem_data    <= pack_nxt;
              mem_wr_addr <= ADDR_WIDTH'(wr_idx) * ADDR_WIDTH'(BYTES);
              wr_idx      <= wr_idx + CNT_WIDTH'(1);
              pack        <= '0;
              beat_cnt    <= '0;
              if (in_last) state <= FLUSH;
            end else begin
              pack     <= pack_nxt;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        FLUSH: begin
          state    <= DONE;
          prog_ack <= 1'b1;
          core_run <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
